interrupt_controller: RTL and testbench

Memory-mapped interrupt controller on the CPU side of the device interrupt lines. It collects the level-sensitive `inta_ready` outputs of bus peripherals (timer, keys, switches, …) and masks them. It selects one by fixed priority, raises a request to the pipeline, and runs the acknowledge/return handshake. It exposes the ID of the in-service source on the data bus so the handler can dispatch.

---
 rtl/interrupt_controller_pkg.sv | 17 +
 rtl/Register.sv | 20 ++
 rtl/irq_priority_encoder.sv | 24 ++
 rtl/interrupt_controller.sv | 132 +++++++++++++
 tb/tb_interrupt_controller.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/interrupt_controller_pkg.sv
// Shared types and constants for the interrupt controller: FSM states, ID width and the
// default memory-mapped register addresses.
package interrupt_controller_pkg;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StReq     = 2'd1,
      StService = 2'd2
   } irq_state_e;

   localparam int unsigned IdWidth = 4;

   localparam logic [31:0] DefaultIdnBase   = 32'hF000_0010;
   localparam logic [31:0] DefaultImaskBase = 32'hF000_0014;
   localparam logic [31:0] DefaultIstatBase = 32'hF000_0018;

endpackage

// File: rtl/Register.sv
// Generic loadable register, asynchronous active-high reset to zero.
module Register #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q <= '0;
      end else if (load) begin
         q <= d;
      end
   end

endmodule

// File: rtl/irq_priority_encoder.sv
// Fixed-priority encoder: lowest set index wins, ID = index + 1, ID 0 means none.
module irq_priority_encoder
   import interrupt_controller_pkg::*;
#(
   parameter int unsigned NUM_SRC = 4
) (
   input  logic [NUM_SRC-1:0] pend,
   output logic               valid,
   output logic [IdWidth-1:0] id
);

   always_comb begin
      valid = 1'b0;
      id    = '0;
      // Walk downwards so the lowest set index is the last one written.
      for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
         if (pend[i]) begin
            valid = 1'b1;
            id    = IdWidth'(i + 1);
         end
      end
   end

endmodule

// File: rtl/interrupt_controller.sv
// Masked fixed-priority interrupt controller with request/acknowledge/return handshake
// and memory-mapped ID, mask and status registers.
module interrupt_controller
   import interrupt_controller_pkg::*;
#(
   parameter int unsigned     BITS       = 32,
   parameter int unsigned     NUM_SRC    = 4,
   parameter logic [BITS-1:0] IDN_BASE   = BITS'(DefaultIdnBase),
   parameter logic [BITS-1:0] IMASK_BASE = BITS'(DefaultImaskBase),
   parameter logic [BITS-1:0] ISTAT_BASE = BITS'(DefaultIstatBase)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               we,
   input  logic               re,
   input  logic [BITS-1:0]    memAddr,
   input  logic [BITS-1:0]    dataBusIn,
   output logic [BITS-1:0]    dataBusOut,
   input  logic [NUM_SRC-1:0] irq_src,
   input  logic               cpu_ie,
   output logic               intr_req,
   input  logic               intr_ack,
   input  logic               intr_ret,
   output logic [BITS-1:0]    debug
);

   logic [NUM_SRC-1:0] mask_q;
   logic [NUM_SRC-1:0] pend;
   logic               pend_valid;
   logic [IdWidth-1:0] pend_id;
   logic               mask_load;
   irq_state_e         state_q, state_d;
   logic [IdWidth-1:0] winner_q, winner_d;
   logic               intr_req_q;
   logic [7:0]         mask_dbg;
   logic               unused_din;

   assign mask_load  = we && (memAddr == IMASK_BASE);
   assign unused_din = ^dataBusIn[BITS-1:NUM_SRC];

   Register #(
      .WIDTH (NUM_SRC)
   ) u_mask_reg (
      .clk   (clk),
      .reset (reset),
      .load  (mask_load),
      .d     (dataBusIn[NUM_SRC-1:0]),
      .q     (mask_q)
   );

   assign pend = irq_src & mask_q;

   irq_priority_encoder #(
      .NUM_SRC (NUM_SRC)
   ) u_prio (
      .pend  (pend),
      .valid (pend_valid),
      .id    (pend_id)
   );

   always_comb begin
      state_d  = state_q;
      winner_d = winner_q;
      unique case (state_q)
         StIdle: begin
            if (cpu_ie && pend_valid) begin
               winner_d = pend_id;
               state_d  = StReq;
            end
         end
         StReq: begin
            // Ack takes precedence over a simultaneous interrupt-enable drop.
            if (intr_ack) begin
               state_d = StService;
            end else if (!cpu_ie) begin
               winner_d = '0;
               state_d  = StIdle;
            end
         end
         StService: begin
            if (intr_ret) begin
               winner_d = '0;
               state_d  = StIdle;
            end
         end
         default: begin
            winner_d = '0;
            state_d  = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= StIdle;
         winner_q   <= '0;
         intr_req_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         winner_q   <= winner_d;
         intr_req_q <= (state_d == StReq);
      end
   end

   assign intr_req = intr_req_q;

   always_comb begin
      mask_dbg              = '0;
      mask_dbg[NUM_SRC-1:0] = mask_q;
   end

   always_comb begin
      dataBusOut = '0;
      if (re && !we) begin
         if (memAddr == IDN_BASE) begin
            dataBusOut = BITS'(winner_q);
         end else if (memAddr == IMASK_BASE) begin
            dataBusOut = BITS'(mask_q);
         end else if (memAddr == ISTAT_BASE) begin
            dataBusOut = BITS'(irq_src);
         end
      end
   end

   always_comb begin
      debug       = '0;
      debug[1:0]  = state_q;
      debug[7:4]  = winner_q;
      debug[15:8] = mask_dbg;
   end

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller: directed vector table, a reset-in-service
// sequence, and randomized traffic compared against a behavioural model.
module tb_interrupt_controller;

   localparam logic [31:0] IDN   = 32'hF000_0010;
   localparam logic [31:0] IMASK = 32'hF000_0014;
   localparam logic [31:0] ISTAT = 32'hF000_0018;

   logic        clk = 1'b0;
   logic        reset;
   logic        we, re;
   logic [31:0] memAddr, dataBusIn, dataBusOut, debug;
   logic [3:0]  irq_src;
   logic        cpu_ie, intr_req, intr_ack, intr_ret;

   int checks = 0;
   int errors = 0;

   // Behavioural model: state 0=idle, 1=request pending, 2=in service.
   int         m_state;
   logic [3:0] m_mask, m_win;
   logic       m_req;

   always #5 clk = ~clk;

   interrupt_controller dut (
      .clk        (clk),
      .reset      (reset),
      .we         (we),
      .re         (re),
      .memAddr    (memAddr),
      .dataBusIn  (dataBusIn),
      .dataBusOut (dataBusOut),
      .irq_src    (irq_src),
      .cpu_ie     (cpu_ie),
      .intr_req   (intr_req),
      .intr_ack   (intr_ack),
      .intr_ret   (intr_ret),
      .debug      (debug)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] model_read();
      if (!(re && !we)) return 32'h0;
      if (memAddr == IDN)   return {28'h0, m_win};
      if (memAddr == IMASK) return {28'h0, m_mask};
      if (memAddr == ISTAT) return {28'h0, irq_src};
      return 32'h0;
   endfunction

   task automatic check_model(input string tag);
      chk({tag, ".req"}, {31'h0, intr_req}, {31'h0, m_req});
      chk({tag, ".debug"}, debug, {16'h0, 4'h0, m_mask, m_win, 2'b00, 2'(m_state)});
      chk({tag, ".rd"}, dataBusOut, model_read());
   endtask

   // Compute the model's next state from current inputs, clock once, then compare.
   task automatic tick(input string tag);
      int         n_state;
      logic [3:0] n_win, n_mask, pend;
      int         lowest;
      pend   = irq_src & m_mask;
      lowest = -1;
      for (int i = 3; i >= 0; i--) if (pend[i]) lowest = i;
      n_state = m_state;
      n_win   = m_win;
      n_mask  = m_mask;
      if (m_state == 0 && cpu_ie && lowest >= 0) begin
         n_state = 1;
         n_win   = 4'(lowest + 1);
      end else if (m_state == 1 && intr_ack) begin
         n_state = 2;
      end else if (m_state == 1 && !cpu_ie) begin
         n_state = 0;
         n_win   = 4'h0;
      end else if (m_state == 2 && intr_ret) begin
         n_state = 0;
         n_win   = 4'h0;
      end
      if (we && memAddr == IMASK) n_mask = dataBusIn[3:0];
      @(posedge clk);
      m_state = n_state;
      m_win   = n_win;
      m_mask  = n_mask;
      m_req   = (n_state == 1);
      #1;
      check_model(tag);
   endtask

   typedef struct {
      logic        we, re;
      logic [31:0] addr, din;
      logic [3:0]  irq;
      logic        ie, ack, ret;
      logic        exp_req;
      logic [1:0]  exp_st;
      logic [3:0]  exp_win;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic w, logic r, logic [31:0] a, logic [31:0] d, logic [3:0] irq,
                               logic ie, logic ack, logic ret, logic rq, logic [1:0] st,
                               logic [3:0] win, logic [31:0] rd);
      vec_t v;
      v.we = w; v.re = r; v.addr = a; v.din = d; v.irq = irq; v.ie = ie; v.ack = ack;
      v.ret = ret; v.exp_req = rq; v.exp_st = st; v.exp_win = win; v.exp_rd = rd;
      return v;
   endfunction

   initial begin
      reset = 1'b1; we = 0; re = 0; memAddr = 0; dataBusIn = 0; irq_src = 0;
      cpu_ie = 0; intr_ack = 0; intr_ret = 0;
      m_state = 0; m_mask = 0; m_win = 0; m_req = 0;
      #3;
      chk("reset.req", {31'h0, intr_req}, 32'h0);
      chk("reset.debug", debug, 32'h0);
      chk("reset.rd", dataBusOut, 32'h0);
      #9 reset = 1'b0;

      //        we re addr   din       irq    ie ack ret  req st win rd
      vecs.push_back(mk(0, 1, ISTAT, 0,        4'b0001, 1, 0, 0, 0, 0, 0, 32'h1));
      vecs.push_back(mk(0, 1, ISTAT, 0,        4'b0001, 1, 0, 0, 0, 0, 0, 32'h1));
      vecs.push_back(mk(1, 0, IMASK, 32'hF,    4'b0001, 1, 0, 0, 0, 0, 0, 32'h0));
      vecs.push_back(mk(0, 1, IMASK, 0,        4'b0110, 1, 0, 0, 1, 1, 2, 32'hF));
      vecs.push_back(mk(0, 1, IDN,   0,        4'b0110, 1, 0, 0, 1, 1, 2, 32'h2));
      vecs.push_back(mk(0, 1, IDN,   0,        4'b0110, 1, 1, 0, 0, 2, 2, 32'h2));
      vecs.push_back(mk(0, 1, IDN,   0,        4'b0100, 1, 0, 0, 0, 2, 2, 32'h2));
      vecs.push_back(mk(0, 1, IDN,   0,        4'b0100, 1, 0, 1, 0, 0, 0, 32'h0));
      vecs.push_back(mk(0, 1, IDN,   0,        4'b0100, 1, 0, 0, 1, 1, 3, 32'h3));
      vecs.push_back(mk(0, 1, IDN,   0,        4'b0100, 0, 0, 0, 0, 0, 0, 32'h0));
      vecs.push_back(mk(0, 1, IDN,   0,        4'b0100, 1, 0, 0, 1, 1, 3, 32'h3));
      vecs.push_back(mk(0, 1, IDN,   0,        4'b0100, 0, 1, 0, 0, 2, 3, 32'h3));
      vecs.push_back(mk(0, 1, IDN,   0,        4'b0101, 1, 1, 0, 0, 2, 3, 32'h3));
      vecs.push_back(mk(0, 1, IDN,   0,        4'b0101, 1, 0, 1, 0, 0, 0, 32'h0));
      vecs.push_back(mk(0, 1, IDN,   0,        4'b0101, 1, 0, 0, 1, 1, 1, 32'h1));
      vecs.push_back(mk(0, 1, IDN,   0,        4'b0101, 1, 1, 0, 0, 2, 1, 32'h1));
      vecs.push_back(mk(0, 1, IDN,   0,        4'b0000, 1, 0, 1, 0, 0, 0, 32'h0));
      vecs.push_back(mk(0, 1, IDN,   0,        4'b0000, 1, 0, 1, 0, 0, 0, 32'h0));
      vecs.push_back(mk(1, 0, IMASK, 32'h2,    4'b0000, 1, 0, 0, 0, 0, 0, 32'h0));
      vecs.push_back(mk(0, 1, IMASK, 0,        4'b0101, 1, 0, 0, 0, 0, 0, 32'h2));
      vecs.push_back(mk(1, 1, IDN,   32'hFFFF, 4'b0000, 1, 0, 0, 0, 0, 0, 32'h0));
      vecs.push_back(mk(1, 1, ISTAT, 32'hFFFF, 4'b0000, 1, 0, 0, 0, 0, 0, 32'h0));
      vecs.push_back(mk(0, 1, IMASK, 0,        4'b0000, 1, 0, 0, 0, 0, 0, 32'h2));

      @(posedge clk); #1;
      foreach (vecs[i]) begin
         we = vecs[i].we; re = vecs[i].re; memAddr = vecs[i].addr; dataBusIn = vecs[i].din;
         irq_src = vecs[i].irq; cpu_ie = vecs[i].ie; intr_ack = vecs[i].ack;
         intr_ret = vecs[i].ret;
         tick($sformatf("vec%0d", i));
         chk($sformatf("vec%0d.req", i), {31'h0, intr_req}, {31'h0, vecs[i].exp_req});
         chk($sformatf("vec%0d.state", i), {30'h0, debug[1:0]}, {30'h0, vecs[i].exp_st});
         chk($sformatf("vec%0d.win", i), {28'h0, debug[7:4]}, {28'h0, vecs[i].exp_win});
         chk($sformatf("vec%0d.rd", i), dataBusOut, vecs[i].exp_rd);
      end

      // Reset while in service clears everything without a clock edge.
      we = 1; re = 0; memAddr = IMASK; dataBusIn = 32'hF; irq_src = 0; cpu_ie = 1;
      intr_ack = 0; intr_ret = 0;
      tick("rst.mask");
      we = 0; irq_src = 4'b1000;
      tick("rst.req");
      intr_ack = 1;
      tick("rst.svc");
      intr_ack = 0;
      chk("rst.pre_state", {30'h0, debug[1:0]}, 32'h2);
      #1 reset = 1'b1;
      m_state = 0; m_win = 0; m_mask = 0; m_req = 0;
      re = 1; memAddr = IMASK;
      #1;
      chk("rst.async_req", {31'h0, intr_req}, 32'h0);
      chk("rst.async_mask", dataBusOut, 32'h0);
      memAddr = IDN;
      #1;
      chk("rst.async_idn", dataBusOut, 32'h0);
      chk("rst.async_debug", debug, 32'h0);
      #2 reset = 1'b0;

      // Randomized traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         we = ($urandom_range(0, 7) == 0);
         re = ($urandom_range(0, 1) == 0);
         case ($urandom_range(0, 3))
            0: memAddr = IDN;
            1: memAddr = IMASK;
            2: memAddr = ISTAT;
            default: memAddr = $urandom;
         endcase
         dataBusIn = $urandom;
         irq_src   = 4'($urandom);
         cpu_ie    = ($urandom_range(0, 7) != 0);
         intr_ack  = ($urandom_range(0, 3) == 0);
         intr_ret  = ($urandom_range(0, 3) == 0);
         tick("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
